// File: rtl/polar_to_screen_pkg.sv
// Shared constants for the polar-to-screen projection and the display draw
// stage: Q8 quarter-wave sine table, 15-degree step constants, FSM encoding.
package polar_to_screen_pkg;

   // Angle steps are 15 degrees each
   localparam int D90  = 6;
   localparam int D360 = 24;

   localparam int TRIG_ENTRIES = 7;

   // sin(k * 15 deg) in Q8, k = 0..6
   localparam logic [8:0] TRIG_T [0:TRIG_ENTRIES-1] = '{
      9'd0, 9'd66, 9'd128, 9'd181, 9'd222, 9'd247, 9'd256
   };

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_LOOKUP  = 3'd1;
   localparam state_t ST_MULT    = 3'd2;
   localparam state_t ST_ADJUST  = 3'd3;
   localparam state_t ST_PENDING = 3'd4;

   // Table read with out-of-range indices returning zero
   function automatic logic [8:0] trig_lookup(input logic [2:0] idx);
      logic [8:0] val;
      val = '0;
      if (idx <= 3'(TRIG_ENTRIES - 1)) begin
         val = TRIG_T[idx];
      end
      return val;
   endfunction

endpackage

// File: rtl/polar_to_screen_trig.sv
// 7-entry combinational Q8 sine ROM, indexed 0..6.
module trig_table_q8
   import polar_to_screen_pkg::*;
(
   input  logic [2:0] index,
   output logic [8:0] value
);

   // Pure table read
   always_comb begin
      value = trig_lookup(index);
   end

endmodule

// File: rtl/polar_to_screen.sv
// Converts a (distance, bearing, heading) measurement into clamped screen
// coordinates and commits them to the outputs only at a frame start.
module polar_to_screen
   import polar_to_screen_pkg::*;
#(
   parameter int ORIGIN_X    = 512,
   parameter int ORIGIN_Y    = 384,
   parameter int SCALE_SHIFT = 0,
   parameter int X_MAX       = 1023,
   parameter int Y_MAX       = 767
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              frame_start,
   input  logic              meas_valid,
   input  logic [7:0]        meas_distance,
   input  logic [4:0]        meas_angle,
   input  logic [4:0]        meas_orientation,
   output logic              meas_ready,
   output logic signed [11:0] center_x,
   output logic signed [11:0] center_y,
   output logic [4:0]        orientation,
   output logic              position_valid,
   output logic              angle_error
);

   localparam int RS_W = ((8 + SCALE_SHIFT) > 11) ? (8 + SCALE_SHIFT) : 11;
   localparam int PW   = RS_W + 9;
   localparam int SW   = PW + 2;

   localparam logic [4:0] A90  = 5'(D90);
   localparam logic [4:0] A180 = 5'(2 * D90);
   localparam logic [4:0] A270 = 5'(3 * D90);
   localparam logic [4:0] A360 = 5'(D360);

   state_t                state;
   logic [7:0]            dist_r;
   logic [4:0]            angle_r;
   logic [4:0]            orient_r;
   logic [1:0]            quad;
   logic [1:0]            quad_r;
   logic [2:0]            k_idx;
   logic [2:0]            kc_idx;
   logic [8:0]            t_k;
   logic [8:0]            t_kc;
   logic [8:0]            xcoef_r;
   logic [8:0]            ycoef_r;
   logic [RS_W-1:0]       rs;
   logic [PW-1:0]         prod_x;
   logic [PW-1:0]         prod_y;
   logic [PW-1:0]         mx_r;
   logic [PW-1:0]         my_r;
   logic                  neg_x;
   logic                  neg_y;
   logic signed [SW-1:0]  dx;
   logic signed [SW-1:0]  dy;
   logic signed [SW-1:0]  sx;
   logic signed [SW-1:0]  sy;
   logic signed [11:0]    x_clamp;
   logic signed [11:0]    y_clamp;
   logic signed [11:0]    pend_x;
   logic signed [11:0]    pend_y;

   assign meas_ready = (state == ST_IDLE);

   // Split the bearing into quadrant and in-quadrant step
   always_comb begin
      quad  = 2'd0;
      k_idx = 3'd0;
      if (angle_r >= A270) begin
         quad  = 2'd3;
         k_idx = 3'(angle_r - A270);
      end else if (angle_r >= A180) begin
         quad  = 2'd2;
         k_idx = 3'(angle_r - A180);
      end else if (angle_r >= A90) begin
         quad  = 2'd1;
         k_idx = 3'(angle_r - A90);
      end else begin
         k_idx = 3'(angle_r);
      end
      kc_idx = 3'(D90) - k_idx;
   end

   trig_table_q8 u_rom_sin (
      .index (k_idx),
      .value (t_k)
   );

   trig_table_q8 u_rom_cos (
      .index (kc_idx),
      .value (t_kc)
   );

   // Scaled range times Q8 coefficients
   always_comb begin
      rs     = RS_W'(dist_r) << SCALE_SHIFT;
      prod_x = PW'(rs) * PW'(xcoef_r);
      prod_y = PW'(rs) * PW'(ycoef_r);
   end

   // Apply quadrant signs, offset by origin, clamp to screen limits
   always_comb begin
      neg_x = (quad_r == 2'd1) || (quad_r == 2'd2);
      neg_y = (quad_r == 2'd2) || (quad_r == 2'd3);
      dx    = signed'(SW'(mx_r));
      dy    = signed'(SW'(my_r));
      if (neg_x) dx = -dx;
      if (neg_y) dy = -dy;
      sx = SW'(ORIGIN_X) + dx;
      sy = SW'(ORIGIN_Y) + dy;
      if (sx[SW-1]) begin
         x_clamp = '0;
      end else if (sx > SW'(X_MAX)) begin
         x_clamp = 12'(X_MAX);
      end else begin
         x_clamp = sx[11:0];
      end
      if (sy[SW-1]) begin
         y_clamp = '0;
      end else if (sy > SW'(Y_MAX)) begin
         y_clamp = 12'(Y_MAX);
      end else begin
         y_clamp = sy[11:0];
      end
   end

   // Measurement FSM and frame-synchronous output commit
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= ST_IDLE;
         dist_r         <= '0;
         angle_r        <= '0;
         orient_r       <= '0;
         quad_r         <= '0;
         xcoef_r        <= '0;
         ycoef_r        <= '0;
         mx_r           <= '0;
         my_r           <= '0;
         pend_x         <= '0;
         pend_y         <= '0;
         center_x       <= 12'(ORIGIN_X);
         center_y       <= 12'(ORIGIN_Y);
         orientation    <= '0;
         position_valid <= 1'b0;
         angle_error    <= 1'b0;
      end else begin
         angle_error <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (meas_valid) begin
                  if (meas_angle < A360) begin
                     dist_r   <= meas_distance;
                     angle_r  <= meas_angle;
                     orient_r <= meas_orientation;
                     state    <= ST_LOOKUP;
                  end else begin
                     angle_error <= 1'b1;
                  end
               end
            end
            ST_LOOKUP: begin
               // In odd quadrants the axis roles rotate by 90 degrees, so the
               // sine and cosine magnitudes swap between x and y.
               quad_r  <= quad;
               xcoef_r <= quad[0] ? t_k  : t_kc;
               ycoef_r <= quad[0] ? t_kc : t_k;
               state   <= ST_MULT;
            end
            ST_MULT: begin
               mx_r  <= prod_x >> 8;
               my_r  <= prod_y >> 8;
               state <= ST_ADJUST;
            end
            ST_ADJUST: begin
               pend_x <= x_clamp;
               pend_y <= y_clamp;
               state  <= ST_PENDING;
            end
            ST_PENDING: begin
               if (frame_start) begin
                  center_x       <= pend_x;
                  center_y       <= pend_y;
                  orientation    <= orient_r;
                  position_valid <= 1'b1;
                  state          <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_polar_to_screen.sv
// Directed self-checking bench: a default-parameter instance and a
// SCALE_SHIFT=2 instance share all stimulus.
module tb_polar_to_screen;

   logic              clk = 1'b0;
   logic              reset;
   logic              frame_start;
   logic              meas_valid;
   logic [7:0]        meas_distance;
   logic [4:0]        meas_angle;
   logic [4:0]        meas_orientation;

   logic              ready_a, ready_b;
   logic signed [11:0] cx_a, cy_a, cx_b, cy_b;
   logic [4:0]        or_a, or_b;
   logic              pv_a, pv_b;
   logic              ae_a, ae_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   polar_to_screen dut (
      .clock            (clk),
      .reset            (reset),
      .frame_start      (frame_start),
      .meas_valid       (meas_valid),
      .meas_distance    (meas_distance),
      .meas_angle       (meas_angle),
      .meas_orientation (meas_orientation),
      .meas_ready       (ready_a),
      .center_x         (cx_a),
      .center_y         (cy_a),
      .orientation      (or_a),
      .position_valid   (pv_a),
      .angle_error      (ae_a)
   );

   polar_to_screen #(.SCALE_SHIFT(2)) dut_s (
      .clock            (clk),
      .reset            (reset),
      .frame_start      (frame_start),
      .meas_valid       (meas_valid),
      .meas_distance    (meas_distance),
      .meas_angle       (meas_angle),
      .meas_orientation (meas_orientation),
      .meas_ready       (ready_b),
      .center_x         (cx_b),
      .center_y         (cy_b),
      .orientation      (or_b),
      .position_valid   (pv_b),
      .angle_error      (ae_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Accept a measurement and run it through to the pending state
   task automatic measure(input logic [7:0] d, input logic [4:0] a, input logic [4:0] o);
      meas_valid       = 1'b1;
      meas_distance    = d;
      meas_angle       = a;
      meas_orientation = o;
      tick();
      meas_valid = 1'b0;
      tick();
      tick();
      tick();
   endtask

   task automatic commit();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   initial begin
      reset            = 1'b1;
      frame_start      = 1'b0;
      meas_valid       = 1'b0;
      meas_distance    = '0;
      meas_angle       = '0;
      meas_orientation = '0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      chk("rst_ready", ready_a, 1);
      chk("rst_cx", cx_a, 512);
      chk("rst_cy", cy_a, 384);
      chk("rst_or", or_a, 0);
      chk("rst_pv", pv_a, 0);
      chk("rst_ae", ae_a, 0);

      // r=100 angle 0
      measure(8'd100, 5'd0, 5'd3);
      chk("pend_ready", ready_a, 0);
      chk("pend_pv_hold", pv_a, 0);
      chk("pend_cx_hold", cx_a, 512);
      commit();
      chk("a0_cx", cx_a, 612);
      chk("a0_cy", cy_a, 384);
      chk("a0_or", or_a, 3);
      chk("a0_pv", pv_a, 1);
      chk("a0_ready", ready_a, 1);

      measure(8'd100, 5'd2, 5'd5);
      commit();
      chk("a2_cx", cx_a, 598);
      chk("a2_cy", cy_a, 434);
      chk("a2_or", or_a, 5);

      measure(8'd100, 5'd14, 5'd26);
      commit();
      chk("a14_cx", cx_a, 426);
      chk("a14_cy", cy_a, 334);
      chk("a14_or_raw", or_a, 26);

      measure(8'd100, 5'd6, 5'd1);
      commit();
      chk("a6_cx", cx_a, 512);
      chk("a6_cy", cy_a, 484);
      chk("s_a6_cx", cx_b, 512);
      chk("s_a6_cy_clamp", cy_b, 767);

      // Illegal angle
      meas_valid = 1'b1;
      meas_angle = 5'd25;
      tick();
      meas_valid = 1'b0;
      chk("bad_ae", ae_a, 1);
      chk("bad_ae_s", ae_b, 1);
      chk("bad_ready", ready_a, 1);
      tick();
      chk("bad_ae_pulse", ae_a, 0);
      commit();
      chk("bad_cx_hold", cx_a, 512);
      chk("bad_cy_hold", cy_a, 484);
      chk("bad_or_hold", or_a, 1);

      // Clamp limits with SCALE_SHIFT=2
      measure(8'd255, 5'd0, 5'd2);
      commit();
      chk("s_a0_cx_clamp", cx_b, 1023);
      chk("s_a0_cy", cy_b, 384);
      chk("a0_255_cx", cx_a, 767);
      measure(8'd255, 5'd12, 5'd4);
      commit();
      chk("s_a12_cx_clamp", cx_b, 0);
      chk("s_a12_cy", cy_b, 384);
      chk("a12_255_cx", cx_a, 257);

      // Busy-time valid ignored; frame_start in ADJUST does not commit
      meas_valid       = 1'b1;
      meas_distance    = 8'd100;
      meas_angle       = 5'd0;
      meas_orientation = 5'd7;
      tick();
      meas_distance    = 8'd50;
      meas_angle       = 5'd6;
      meas_orientation = 5'd9;
      tick();
      chk("busy_ready", ready_a, 0);
      tick();
      meas_valid  = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("adj_fs_cx", cx_a, 257);
      chk("adj_fs_or", or_a, 4);
      chk("busy_ae", ae_a, 0);
      commit();
      chk("first_cx", cx_a, 612);
      chk("first_cy", cy_a, 384);
      chk("first_or", or_a, 7);

      // Reset while pending
      measure(8'd100, 5'd2, 5'd11);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rp_cx", cx_a, 512);
      chk("rp_cy", cy_a, 384);
      chk("rp_or", or_a, 0);
      chk("rp_pv", pv_a, 0);
      chk("rp_ready", ready_a, 1);
      commit();
      chk("rp_fs_cx", cx_a, 512);
      chk("rp_fs_cy", cy_a, 384);
      chk("rp_fs_pv", pv_a, 0);
      chk("rp_fs_pv_s", pv_b, 0);
      chk("rp_fs_or_s", or_b, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
